// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path.
//   fetch_state_e : fetch controller state encoding (BOOT / FETCH / HALTED)
//   DEF_RESET_PC  : default boot address, must match the PC register reset
//   DEF_EXC_VEC   : default exception handler entry address
//   INSTR_W       : instruction / address word width
package mips_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: picks the next PC and the PC write enable each
// cycle, arbitrating exception redirects, ID-stage branch redirects, hazard
// stalls and sequential fetch, all paced by the instruction-memory ack.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pc                current PC register value
//   stall_d           hazard-unit stall request
//   br_taken_d        ID-stage taken branch/jump
//   br_target_d       redirect target, valid with br_taken_d
//   exc_req           exception redirect request (single-cycle pulse)
//   halt              stop fetching until reset
//   imem_ack          instruction memory returned the word for pc
//   npc               next PC (PC register input)
//   PCEnF             PC write enable
//   imem_req          fetch request for address pc
//   flush_d           discard the instruction entering IF/ID this cycle
//   redirect_pending  a redirect is latched and waiting on imem_ack
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] pc,
  input  logic               stall_d,
  input  logic               br_taken_d,
  input  logic [INSTR_W-1:0] br_target_d,
  input  logic               exc_req,
  input  logic               halt,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] npc,
  output logic               PCEnF,
  output logic               imem_req,
  output logic               flush_d,
  output logic               redirect_pending
);

  localparam int DATA_W = INSTR_W;

  fetch_state_e      state;
  logic              imem_req_q;
  logic              pend_tgt_vld;
  logic              pend_exc;
  logic [DATA_W-1:0] pend_tgt;

  logic              exc_now;
  logic              redir_now;
  logic [DATA_W-1:0] tgt_now;
  logic              tgt_load;

  // Every PC source is forced onto a word boundary.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
    return a & ~DATA_W'(3);
  endfunction

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [DATA_W-1:0] seq_pc(input logic [DATA_W-1:0] a);
    return a + DATA_W'(4);
  endfunction

  // A pending target shadows any new br_taken_d: once a redirect is latched,
  // later branches in ID are on the wrong path.
  assign exc_now   = exc_req | pend_exc;
  assign redir_now = pend_tgt_vld | br_taken_d;
  assign tgt_now   = pend_tgt_vld ? pend_tgt : br_target_d;
  assign tgt_load  = (state == FETCH) && !halt && !imem_ack && br_taken_d && !pend_tgt_vld;

  always_comb begin
    npc     = word_align(pc);
    PCEnF   = 1'b0;
    flush_d = 1'b0;
    unique case (state)
      BOOT: npc = word_align(RESET_PC);
      FETCH: begin
        if (!halt && imem_ack) begin
          if (exc_now) begin
            npc     = word_align(EXC_VEC);
            PCEnF   = 1'b1;
            flush_d = 1'b1;
          end else if (redir_now) begin
            npc     = word_align(tgt_now);
            PCEnF   = 1'b1;
            flush_d = 1'b1;
          end else if (!stall_d) begin
            npc   = word_align(seq_pc(pc));
            PCEnF = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Control: state, request and pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      imem_req_q   <= 1'b0;
      pend_tgt_vld <= 1'b0;
      pend_exc     <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state        <= FETCH;
          imem_req_q   <= 1'b1;
          pend_tgt_vld <= 1'b0;
          pend_exc     <= 1'b0;
        end
        FETCH: begin
          if (halt) begin
            state        <= HALTED;
            imem_req_q   <= 1'b0;
            pend_tgt_vld <= 1'b0;
            pend_exc     <= 1'b0;
          end else if (imem_ack) begin
            // Any redirect taken on this ack consumes both pending entries;
            // an exception also discards a pending branch target.
            if (exc_now || redir_now) begin
              pend_tgt_vld <= 1'b0;
              pend_exc     <= 1'b0;
            end
          end else begin
            if (exc_req) pend_exc <= 1'b1;
            if (tgt_load) pend_tgt_vld <= 1'b1;
          end
        end
        HALTED: begin
          state      <= HALTED;
          imem_req_q <= 1'b0;
        end
        default: begin
          state      <= BOOT;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Data: pending target value, qualified by pend_tgt_vld.
  always_ff @(posedge clk) begin
    if (tgt_load) pend_tgt <= br_target_d;
  end

  assign imem_req         = imem_req_q;
  assign redirect_pending = pend_tgt_vld | pend_exc;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        stall_d;
  logic        br_taken_d;
  logic [31:0] br_target_d;
  logic        exc_req;
  logic        halt;
  logic        imem_ack;
  logic [31:0] npc;
  logic        PCEnF;
  logic        imem_req;
  logic        flush_d;
  logic        redirect_pending;

  logic        force_en;
  logic [31:0] force_val;

  typedef struct {
    int          id;
    logic [31:0] npc;
    logic        pcen;
    logic        flush;
    logic        req;
    logic        rp;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_fail;
  int   next_id;

  fetch_ctrl #(
    .RESET_PC(32'h0000_3000),
    .EXC_VEC (32'h0000_4180)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .stall_d         (stall_d),
    .br_taken_d      (br_taken_d),
    .br_target_d     (br_target_d),
    .exc_req         (exc_req),
    .halt            (halt),
    .imem_ack        (imem_ack),
    .npc             (npc),
    .PCEnF           (PCEnF),
    .imem_req        (imem_req),
    .flush_d         (flush_d),
    .redirect_pending(redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model; force path lets the bench plant arbitrary addresses.
  always @(posedge clk or posedge rst) begin
    if (rst)           pc <= 32'h0000_3000;
    else if (force_en) pc <= force_val;
    else if (PCEnF)    pc <= npc;
  end

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL chk%0d %s: got %h expected %h", id, nm, act, req);
    end
  endtask

  // Monitor: outputs are compared mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.id, "npc", npc, e.npc);
      chk(e.id, "PCEnF", {31'd0, PCEnF}, {31'd0, e.pcen});
      chk(e.id, "flush_d", {31'd0, flush_d}, {31'd0, e.flush});
      chk(e.id, "imem_req", {31'd0, imem_req}, {31'd0, e.req});
      chk(e.id, "redirect_pending", {31'd0, redirect_pending}, {31'd0, e.rp});
      chk(e.id, "pc", pc, e.pc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [31:0] enpc, input logic epcen, input logic eflush,
                    input logic ereq, input logic erp, input logic [31:0] epc);
    exp_t e;
    next_id++;
    e.id = next_id; e.npc = enpc; e.pcen = epcen; e.flush = eflush;
    e.req = ereq; e.rp = erp; e.pc = epc;
    q.push_back(e);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; next_id = 0;
    rst = 1'b1; stall_d = 1'b0; br_taken_d = 1'b0; br_target_d = 32'h0;
    exc_req = 1'b0; halt = 1'b0; imem_ack = 1'b1;
    force_en = 1'b0; force_val = 32'h0;

    // Reset and boot, sequential fetch with ack tied high
    cyc(); ex(32'h3000, 0, 0, 0, 0, 32'h3000);
    cyc(); rst = 1'b0; ex(32'h3000, 0, 0, 0, 0, 32'h3000);
    cyc(); ex(32'h3004, 1, 0, 1, 0, 32'h3000);
    cyc(); ex(32'h3008, 1, 0, 1, 0, 32'h3004);
    cyc(); ex(32'h300C, 1, 0, 1, 0, 32'h3008);
    cyc(); ex(32'h3010, 1, 0, 1, 0, 32'h300C);

    // Branch arrives without ack, waits three cycles
    cyc(); br_taken_d = 1; br_target_d = 32'h3100; imem_ack = 0;
    ex(32'h3010, 0, 0, 1, 0, 32'h3010);
    cyc(); br_taken_d = 0; ex(32'h3010, 0, 0, 1, 1, 32'h3010);
    cyc(); ex(32'h3010, 0, 0, 1, 1, 32'h3010);
    cyc(); imem_ack = 1; ex(32'h3100, 1, 1, 1, 1, 32'h3010);
    cyc(); ex(32'h3104, 1, 0, 1, 0, 32'h3100);

    // Pending target overridden by a later exception
    cyc(); br_taken_d = 1; br_target_d = 32'h3100; imem_ack = 0;
    ex(32'h3104, 0, 0, 1, 0, 32'h3104);
    cyc(); br_taken_d = 0; exc_req = 1; ex(32'h3104, 0, 0, 1, 1, 32'h3104);
    cyc(); exc_req = 0; ex(32'h3104, 0, 0, 1, 1, 32'h3104);
    cyc(); imem_ack = 1; ex(32'h4180, 1, 1, 1, 1, 32'h3104);
    cyc(); ex(32'h4184, 1, 0, 1, 0, 32'h4180);

    // Second branch while one is pending is wrong-path
    cyc(); br_taken_d = 1; br_target_d = 32'h5000; imem_ack = 0;
    ex(32'h4184, 0, 0, 1, 0, 32'h4184);
    cyc(); br_target_d = 32'h6000; ex(32'h4184, 0, 0, 1, 1, 32'h4184);
    cyc(); br_taken_d = 0; imem_ack = 1; ex(32'h5000, 1, 1, 1, 1, 32'h4184);

    // Branch together with ack redirects on the next edge
    cyc(); br_taken_d = 1; br_target_d = 32'h3020; ex(32'h3020, 1, 1, 1, 0, 32'h5000);

    // Two stalled acked cycles, then release
    cyc(); br_taken_d = 0; stall_d = 1; ex(32'h3020, 0, 0, 1, 0, 32'h3020);
    cyc(); ex(32'h3020, 0, 0, 1, 0, 32'h3020);
    cyc(); stall_d = 0; ex(32'h3024, 1, 0, 1, 0, 32'h3020);

    // Wraparound of pc+4, then misaligned branch target
    cyc(); imem_ack = 0; force_en = 1; force_val = 32'hFFFF_FFFC;
    ex(32'h3024, 0, 0, 1, 0, 32'h3024);
    cyc(); force_en = 0; imem_ack = 1; ex(32'h0000_0000, 1, 0, 1, 0, 32'hFFFF_FFFC);
    cyc(); br_taken_d = 1; br_target_d = 32'h3103; ex(32'h3100, 1, 1, 1, 0, 32'h0000_0000);

    // Halt beats a simultaneous acked branch, then stays halted
    cyc(); halt = 1; br_target_d = 32'h7000; ex(32'h3100, 0, 0, 1, 0, 32'h3100);
    cyc(); halt = 0; br_taken_d = 0; ex(32'h3100, 0, 0, 0, 0, 32'h3100);
    cyc(); exc_req = 1; ex(32'h3100, 0, 0, 0, 0, 32'h3100);

    // Asynchronous reset mid-cycle, then boot again
    cyc(); exc_req = 0; rst = 1; ex(32'h3000, 0, 0, 0, 0, 32'h3000);
    cyc(); rst = 0; ex(32'h3000, 0, 0, 0, 0, 32'h3000);
    cyc(); ex(32'h3004, 1, 0, 1, 0, 32'h3000);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
